// File: rtl/ergs_pkg.sv
// Phase encodings and event bit indices shared between the stroke phase detector
// and the downstream rush calculator.
package ergs_pkg;

  localparam logic [1:0] PH_IDLE     = 2'd0;
  localparam logic [1:0] PH_DRIVE    = 2'd1;
  localparam logic [1:0] PH_RECOVERY = 2'd2;

  // Bit index doubles as issue priority: lower index leaves the queue first.
  localparam int EV_START_REC  = 0;
  localparam int EV_START_REF1 = 1;
  localparam int EV_START_REF2 = 2;
  localparam int EV_END_REF1   = 3;
  localparam int EV_END_REC    = 4;
  localparam int EV_N          = 5;

  localparam int N_REFS = 3;

  typedef logic [EV_N-1:0] ev_mask_t;

  // Isolates the lowest set bit (highest-priority pending event).
  function automatic ev_mask_t ev_first(input ev_mask_t m);
    return m & (~m + EV_N'(1));
  endfunction

endpackage

// File: rtl/stroke_phase_detector_if.sv
// Handle-position sample input plus the stroke-phase event outputs of the detector.
interface stroke_phase_detector_if #(
  parameter int POS_W = 12
);
  logic             pos_valid;
  logic [POS_W-1:0] pos;
  logic             start_recovery;
  logic             start_ref1;
  logic             start_ref2;
  logic             end_ref1;
  logic             end_recovery;
  logic [1:0]       phase;
  logic [15:0]      stroke_count;

  modport master (
    output pos_valid, pos,
    input  start_recovery, start_ref1, start_ref2, end_ref1, end_recovery, phase, stroke_count
  );

  modport slave (
    input  pos_valid, pos,
    output start_recovery, start_ref1, start_ref2, end_ref1, end_recovery, phase, stroke_count
  );
endinterface

// File: rtl/stroke_event_queue.sv
// Pending-event mask with merge-on-set and a fixed-priority one-hot issue stage:
// at most one registered pulse per cycle, lowest event index first.
module stroke_event_queue
  import ergs_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  ev_mask_t i_set,
  input  logic     i_clear,
  output ev_mask_t o_pulse
);

  ev_mask_t r_pend;
  ev_mask_t r_pulse;
  ev_mask_t w_merged;
  ev_mask_t w_issue;

  // New events join the mask before selection so an empty queue issues next cycle.
  assign w_merged = r_pend | i_set;
  assign w_issue  = ev_first(w_merged);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend  <= '0;
      r_pulse <= '0;
    end else if (i_clear) begin
      r_pend  <= '0;
      r_pulse <= '0;
    end else begin
      r_pend  <= w_merged & ~w_issue;
      r_pulse <= w_issue;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/stroke_phase_detector.sv
// Drive/recovery phase tracker for the erg handle: hysteretic direction detection,
// reference-point crossing events, stroke counting and an inactivity timeout.
module stroke_phase_detector
  import ergs_pkg::*;
#(
  parameter int POS_W       = 12,
  parameter int HYST        = 16,
  parameter int REF1_POS    = 2400,
  parameter int REF2_POS    = 1600,
  parameter int END_REF_POS = 800,
  parameter int TIMEOUT_CYC = 2**24
) (
  input logic                    clk,
  input logic                    rst_n,
  stroke_phase_detector_if.slave sp_bus
);

  localparam int W    = POS_W + 1;
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [N_REFS*W-1:0] REF_THR = {W'(END_REF_POS), W'(REF2_POS), W'(REF1_POS)};

  logic [1:0]        r_phase, w_phase_next;
  logic [POS_W-1:0]  r_pk, w_pk_next;
  logic [POS_W-1:0]  r_tr, w_tr_next;
  logic [POS_W-1:0]  r_last_pos, w_last_pos;
  logic [N_REFS-1:0] r_armed, w_armed_next;
  logic [15:0]       r_count, w_count_next;
  logic [TO_W-1:0]   r_to_cnt, w_to_cnt_next;

  logic [W-1:0]      w_pos, w_pk, w_tr, w_hyst;
  logic [N_REFS-1:0] w_ref_hit, w_ref_above_pk;
  logic              w_trans, w_timeout;
  ev_mask_t          w_set, w_pulse;

  assign w_pos  = {1'b0, sp_bus.pos};
  assign w_pk   = {1'b0, r_pk};
  assign w_tr   = {1'b0, r_tr};
  assign w_hyst = W'(HYST);
  assign w_last_pos = sp_bus.pos_valid ? sp_bus.pos : r_last_pos;

  // A ref only counts as crossed downward if the stroke peak was above it,
  // so a short stroke never fires the refs it never reached.
  for (genvar gi = 0; gi < N_REFS; gi++) begin : g_ref
    assign w_ref_hit[gi]      = (w_pos <= REF_THR[gi*W +: W]);
    assign w_ref_above_pk[gi] = (w_pk  >  REF_THR[gi*W +: W]);
  end

  always_comb begin
    w_phase_next = r_phase;
    w_pk_next    = r_pk;
    w_tr_next    = r_tr;
    w_armed_next = r_armed;
    w_count_next = r_count;
    w_set        = '0;
    w_trans      = 1'b0;
    if (sp_bus.pos_valid) begin
      case (r_phase)
        PH_IDLE: begin
          if (w_pos >= w_tr + w_hyst) begin
            w_phase_next = PH_DRIVE;
            w_pk_next    = sp_bus.pos;
            w_trans      = 1'b1;
          end else if (sp_bus.pos < r_tr) begin
            w_tr_next = sp_bus.pos;
          end
        end
        PH_DRIVE: begin
          if (w_pos + w_hyst <= w_pk) begin
            w_phase_next = PH_RECOVERY;
            w_tr_next    = sp_bus.pos;
            w_trans      = 1'b1;
            w_set[EV_START_REC] = 1'b1;
            w_set[EV_END_REF1:EV_START_REF1] = w_ref_above_pk & w_ref_hit;
            w_armed_next = w_ref_above_pk & ~w_ref_hit;
          end else if (sp_bus.pos > r_pk) begin
            w_pk_next = sp_bus.pos;
          end
        end
        PH_RECOVERY: begin
          if (w_pos >= w_tr + w_hyst) begin
            w_phase_next = PH_DRIVE;
            w_pk_next    = sp_bus.pos;
            w_trans      = 1'b1;
            w_count_next = r_count + 16'd1;
            w_set[EV_END_REC] = 1'b1;
          end else begin
            if (sp_bus.pos < r_tr) w_tr_next = sp_bus.pos;
            w_set[EV_END_REF1:EV_START_REF1] = r_armed & w_ref_hit;
            w_armed_next = r_armed & ~w_ref_hit;
          end
        end
        default: w_phase_next = PH_IDLE;
      endcase
    end

    // A transition on the same cycle always beats the timeout.
    w_timeout = !w_trans && (r_phase != PH_IDLE) && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
    if (w_timeout) begin
      w_phase_next = PH_IDLE;
      w_tr_next    = w_last_pos;
    end

    if (w_trans || w_timeout)
      w_to_cnt_next = '0;
    else if (r_to_cnt != TO_W'(TIMEOUT_CYC))
      w_to_cnt_next = r_to_cnt + TO_W'(1);
    else
      w_to_cnt_next = r_to_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase    <= PH_IDLE;
      r_pk       <= '0;
      r_tr       <= '0;
      r_last_pos <= '0;
      r_armed    <= '0;
      r_count    <= '0;
      r_to_cnt   <= '0;
    end else begin
      r_phase    <= w_phase_next;
      r_pk       <= w_pk_next;
      r_tr       <= w_tr_next;
      r_last_pos <= w_last_pos;
      r_armed    <= w_armed_next;
      r_count    <= w_count_next;
      r_to_cnt   <= w_to_cnt_next;
    end
  end

  stroke_event_queue u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_set   (w_set),
    .i_clear (w_timeout),
    .o_pulse (w_pulse)
  );

  assign sp_bus.start_recovery = w_pulse[EV_START_REC];
  assign sp_bus.start_ref1     = w_pulse[EV_START_REF1];
  assign sp_bus.start_ref2     = w_pulse[EV_START_REF2];
  assign sp_bus.end_ref1       = w_pulse[EV_END_REF1];
  assign sp_bus.end_recovery   = w_pulse[EV_END_REC];
  assign sp_bus.phase          = r_phase;
  assign sp_bus.stroke_count   = r_count;

endmodule

// File: tb/tb_stroke_phase_detector.sv
// Scoreboarded bench: a per-sample stroke model predicts pulses, phase and count;
// a negedge monitor compares whatever the detector presents against the queued expectations.
module tb_stroke_phase_detector;
  import ergs_pkg::*;

  localparam int POS_W = 12;
  localparam int HYST  = 16;
  localparam int REF1  = 2400;
  localparam int REF2  = 1600;
  localparam int ENDR  = 800;
  localparam int TO    = 300;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  stroke_phase_detector_if #(.POS_W(POS_W)) bus ();

  stroke_phase_detector #(
    .POS_W(POS_W), .HYST(HYST), .REF1_POS(REF1), .REF2_POS(REF2),
    .END_REF_POS(ENDR), .TIMEOUT_CYC(TO)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sp_bus (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int passes = 0;

  typedef struct { int cyc; logic [4:0] ev; } pulse_exp_t;
  typedef struct { int cyc; logic [1:0] ph; logic [15:0] cnt; } state_exp_t;
  pulse_exp_t pq[$];
  state_exp_t sq[$];
  pulse_exp_t pe;
  state_exp_t se;

  // Reference model state, in plain integer terms.
  int          m_phase, m_pk, m_tr, m_last, m_quiet;
  bit   [2:0]  m_armed;
  logic [15:0] m_count;
  logic [4:0]  m_pend;
  int          thr[3] = '{REF1, REF2, ENDR};

  function automatic void chk(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, got, exp);
  endfunction

  function automatic void model_reset();
    m_phase = 0; m_pk = 0; m_tr = 0; m_last = 0; m_quiet = 0;
    m_armed = '0; m_count = '0; m_pend = '0;
    pq.delete();
    sq.delete();
  endfunction

  function automatic void model_step(input bit v, input int p);
    logic [4:0] ev = '0;
    logic [4:0] issue = '0;
    bit moved = 0;
    bit timed = 0;
    if (v) begin
      m_last = p;
      if (m_phase == 0) begin
        if (p >= m_tr + HYST) begin m_phase = 1; m_pk = p; moved = 1; end
        else if (p < m_tr) m_tr = p;
      end else if (m_phase == 1) begin
        if (p <= m_pk - HYST) begin
          m_phase = 2; m_tr = p; moved = 1; ev[0] = 1'b1;
          for (int i = 0; i < 3; i++) m_armed[i] = (m_pk > thr[i]);
        end else if (p > m_pk) m_pk = p;
      end else begin
        if (p >= m_tr + HYST) begin
          m_phase = 1; m_pk = p; moved = 1; ev[4] = 1'b1; m_count = m_count + 16'd1;
        end else if (p < m_tr) m_tr = p;
      end
      if (m_phase == 2 && ev[4] == 1'b0)
        for (int i = 0; i < 3; i++)
          if (m_armed[i] && p <= thr[i]) begin ev[1+i] = 1'b1; m_armed[i] = 1'b0; end
    end
    if (moved) m_quiet = 0;
    else if (m_phase != 0 && m_quiet == TO - 1) begin
      timed = 1; m_phase = 0; m_tr = m_last; m_quiet = 0;
    end else if (m_quiet < TO) m_quiet++;
    m_pend = m_pend | ev;
    if (timed) m_pend = '0;
    else begin
      for (int i = 4; i >= 0; i--) if (m_pend[i]) issue = 5'(1 << i);
      m_pend = m_pend & ~issue;
    end
    if (issue != '0) pq.push_back('{cyc + 1, issue});
    sq.push_back('{cyc + 1, 2'(m_phase), m_count});
  endfunction

  task automatic drive(input bit v, input int p);
    @(posedge clk);
    #1;
    bus.pos_valid = v;
    bus.pos       = POS_W'(p);
    model_step(v, p);
  endtask

  task automatic ramp(input int from, input int to, input int step);
    if (from <= to) for (int x = from; x <= to; x += step) drive(1'b1, x);
    else            for (int x = from; x >= to; x -= step) drive(1'b1, x);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, int'($urandom_range(0, 4095)));
  endtask

  // Walks toward target in random steps with random gaps in pos_valid.
  task automatic move_to(inout int cur, input int target, input int step);
    while (cur != target) begin
      if ($urandom_range(0, 4) == 0) drive(1'b0, int'($urandom_range(0, 4095)));
      else begin
        if (cur < target) cur = (cur + step > target) ? target : cur + step;
        else              cur = (cur - step < target) ? target : cur - step;
        drive(1'b1, cur);
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pulses"}, int'({bus.end_recovery, bus.end_ref1, bus.start_ref2,
                                 bus.start_ref1, bus.start_recovery}), 0);
    chk({tag, "_phase"}, int'(bus.phase), int'(PH_IDLE));
    chk({tag, "_count"}, int'(bus.stroke_count), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      logic [4:0] got;
      got = {bus.end_recovery, bus.end_ref1, bus.start_ref2, bus.start_ref1, bus.start_recovery};
      if (pq.size() > 0 && pq[0].cyc == cyc) begin
        pe = pq.pop_front();
        chk("pulse", int'(got), int'(pe.ev));
      end else if (got != '0) begin
        checks++;
        $display("FAIL unexpected_pulse cyc=%0d actual=%b required=00000", cyc, got);
      end
      if (sq.size() > 0 && sq[0].cyc == cyc) begin
        se = sq.pop_front();
        chk("phase", int'(bus.phase), int'(se.ph));
        chk("stroke_count", int'(bus.stroke_count), int'(se.cnt));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cur;
    bus.pos_valid = 1'b0;
    bus.pos       = '0;
    model_reset();
    #2 rst_n = 1'b0;
    #1 chk_all_zero("reset");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Full ramp stroke: every event once, in order.
    ramp(0, 3000, 20);
    ramp(3000, 0, 20);
    ramp(0, 3000, 20);
    idle(5);
    chk("t1_phase", int'(bus.phase), int'(PH_DRIVE));
    chk("t1_count", int'(bus.stroke_count), 1);

    // One-sample plunge through all refs, then a catch.
    drive(1'b1, 500);
    idle(6);
    drive(1'b1, 300);
    drive(1'b1, 1000);
    idle(3);
    chk("t2_count", int'(bus.stroke_count), 2);

    // Short stroke: peak below REF1, trough exactly through REF2.
    ramp(1000, 2000, 50);
    ramp(2000, 1500, 50);
    ramp(1500, 1800, 50);
    idle(3);
    chk("t3_count", int'(bus.stroke_count), 3);

    // Stall in recovery until the timeout drops back to IDLE.
    ramp(1800, 3000, 100);
    drive(1'b1, 2500);
    idle(TO + 10);
    chk("t5_phase", int'(bus.phase), int'(PH_IDLE));
    chk("t5_count", int'(bus.stroke_count), 3);

    // Jitter narrower than the hysteresis stays IDLE.
    repeat (60) drive(1'b1, 2500 + int'($urandom_range(0, 14)) - 7);
    chk("t4_phase", int'(bus.phase), int'(PH_IDLE));

    // Reset while three events are still pending.
    ramp(2600, 3000, 100);
    drive(1'b1, 500);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bus.pos_valid = 1'b0;
    #1 chk_all_zero("t6_async");
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    idle(8);
    chk("t6_phase", int'(bus.phase), int'(PH_IDLE));

    // Randomised strokes with sample gaps, full-scale peaks and occasional stalls.
    cur = 0;
    for (int s = 0; s < 250; s++) begin
      int peak, trough;
      peak   = int'($urandom_range(1200, 4095));
      trough = int'($urandom_range(0, peak - 400));
      move_to(cur, peak, int'($urandom_range(10, 400)));
      move_to(cur, trough, int'($urandom_range(10, 400)));
      if ($urandom_range(0, 39) == 0) idle(TO + 2);
    end

    idle(10);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("pulse_queue_drained", pq.size(), 0);
    chk("state_queue_drained", sq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
